// File: rtl/morra_pkg.sv
// Shared types and constants for the MorraCinese match sequencer.
package morra_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    SASSO   = 2'b01,
    CARTA   = 2'b10,
    FORBICE = 2'b11
  } move_t;

  // RES_RUN doubles as "invalid manche" on the core_manche bus.
  typedef enum logic [1:0] {
    RES_RUN     = 2'b00,
    RES_PRIMO   = 2'b01,
    RES_SECONDO = 2'b10,
    RES_TIE     = 2'b11
  } result_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_WAIT_MOVES,
    ST_ISSUE,
    ST_RESULT,
    ST_GAME_END,
    ST_DONE
  } ctrl_state_t;

  localparam logic [4:0] MANCHE_MIN = 5'd4;
  localparam logic [4:0] MANCHE_MAX = 5'd19;

  function automatic logic [4:0] clamp_manche(input logic [4:0] m);
    if (m < MANCHE_MIN) return MANCHE_MIN;
    if (m > MANCHE_MAX) return MANCHE_MAX;
    return m;
  endfunction

endpackage

// File: rtl/morra_move_slot.sv
// One-entry move latch for a single player port; only non-NONE moves fill it.
module morra_move_slot
  import morra_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clear,
  input  logic       valid,
  input  logic [1:0] move_in,
  output logic       ready,
  output logic       full,
  output logic       fill,
  output logic [1:0] move_out
);

  move_t move_q, move_d;
  logic  full_q, full_d;

  always_comb begin
    ready  = en && !full_q;
    fill   = valid && ready && (move_in != NONE);
    full_d = full_q;
    move_d = move_q;
    if (clear) begin
      full_d = 1'b0;
      move_d = NONE;
    end else if (fill) begin
      full_d = 1'b1;
      move_d = move_t'(move_in);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      move_q <= NONE;
    end else begin
      full_q <= full_d;
      move_q <= move_d;
    end
  end

  assign full     = full_q;
  assign move_out = move_q;

endmodule

// File: rtl/morra_match_ctrl.sv
// Match sequencer between two player ports and the MorraCinese core.
// Optional stall abort enabled by defining MORRA_TIMEOUT_EN.
module morra_match_ctrl
  import morra_pkg::*;
#(
  parameter int CNT_W = 4
`ifdef MORRA_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       cfg_max_manche,
  input  logic [CNT_W-1:0] cfg_num_games,
  input  logic [1:0]       p1_move,
  input  logic [1:0]       p2_move,
  input  logic             p1_valid,
  input  logic             p2_valid,
  output logic             p1_ready,
  output logic             p2_ready,
  output logic [1:0]       core_primo,
  output logic [1:0]       core_secondo,
  output logic             core_inizia,
  input  logic [1:0]       core_manche,
  input  logic [1:0]       core_partita,
  output logic             round_valid,
  output logic [1:0]       round_result,
  output logic             game_valid,
  output logic [1:0]       game_result,
  output logic [CNT_W-1:0] p1_wins,
  output logic [CNT_W-1:0] p2_wins,
  output logic [CNT_W-1:0] ties,
  output logic             busy,
  output logic             done
`ifdef MORRA_TIMEOUT_EN
  , output logic           abort
`endif
);

  ctrl_state_t      state_q, state_d;
  logic [4:0]       max_q, max_d;
  logic [CNT_W-1:0] num_q, num_d, games_q, games_d;
  logic [CNT_W-1:0] p1w_q, p1w_d, p2w_q, p2w_d, tie_q, tie_d;
  result_t          round_res_q, round_res_d, game_res_q, game_res_d;
  logic             slot_en, slot_clr;
  logic             p1_full, p1_fill, p2_full, p2_fill;
  logic [1:0]       p1_slot_move, p2_slot_move;

`ifdef MORRA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             abort_q, abort_d;
  logic             any_accept;
  assign any_accept = (p1_valid && p1_ready) || (p2_valid && p2_ready);
  assign abort      = abort_q;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  morra_move_slot u_slot_p1 (
    .clk(clk), .rst_n(rst_n), .en(slot_en), .clear(slot_clr),
    .valid(p1_valid), .move_in(p1_move), .ready(p1_ready),
    .full(p1_full), .fill(p1_fill), .move_out(p1_slot_move)
  );

  morra_move_slot u_slot_p2 (
    .clk(clk), .rst_n(rst_n), .en(slot_en), .clear(slot_clr),
    .valid(p2_valid), .move_in(p2_move), .ready(p2_ready),
    .full(p2_full), .fill(p2_fill), .move_out(p2_slot_move)
  );

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    max_d        = max_q;
    num_d        = num_q;
    games_d      = games_q;
    p1w_d        = p1w_q;
    p2w_d        = p2w_q;
    tie_d        = tie_q;
    round_res_d  = round_res_q;
    game_res_d   = game_res_q;
    slot_en      = 1'b0;
    slot_clr     = 1'b0;
    core_primo   = NONE;
    core_secondo = NONE;
    core_inizia  = 1'b0;
    round_valid  = 1'b0;
    round_result = round_res_q;
    game_valid   = 1'b0;
    done         = 1'b0;
`ifdef MORRA_TIMEOUT_EN
    tmo_d   = '0;
    abort_d = abort_q;
`endif
    unique case (state_q)
      ST_IDLE: if (start) begin
        max_d   = clamp_manche(cfg_max_manche);
        num_d   = (cfg_num_games == '0) ? CNT_W'(1) : cfg_num_games;
        games_d = '0;
        p1w_d   = '0;
        p2w_d   = '0;
        tie_d   = '0;
`ifdef MORRA_TIMEOUT_EN
        abort_d = 1'b0;
`endif
        state_d = ST_CONFIG;
      end
      ST_CONFIG: begin
        core_inizia                 = 1'b1;
        {core_primo, core_secondo}  = 4'(max_q - MANCHE_MIN);
        state_d                     = ST_WAIT_MOVES;
      end
      ST_WAIT_MOVES: begin
        slot_en = 1'b1;
        // Look at the slots' next state so ISSUE follows the filling edge directly.
        if ((p1_full || p1_fill) && (p2_full || p2_fill)) begin
          state_d = ST_ISSUE;
        end
`ifdef MORRA_TIMEOUT_EN
        else if (any_accept) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          abort_d    = 1'b1;
          slot_clr   = 1'b1;
          game_res_d = (p1_full && !p2_full) ? RES_PRIMO :
                       (p2_full && !p1_full) ? RES_SECONDO : RES_TIE;
          state_d    = ST_GAME_END;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      ST_ISSUE: begin
        core_primo   = p1_slot_move;
        core_secondo = p2_slot_move;
        slot_clr     = 1'b1;
        state_d      = ST_RESULT;
      end
      ST_RESULT: begin
        round_valid  = 1'b1;
        round_result = core_manche;
        round_res_d  = result_t'(core_manche);
        if (core_partita == RES_RUN) begin
          state_d = ST_WAIT_MOVES;
        end else begin
          game_res_d = result_t'(core_partita);
          state_d    = ST_GAME_END;
        end
      end
      ST_GAME_END: begin
        game_valid = 1'b1;
        games_d    = games_q + CNT_W'(1);
        case (game_res_q)
          RES_PRIMO:   p1w_d = sat_inc(p1w_q);
          RES_SECONDO: p2w_d = sat_inc(p2w_q);
          RES_TIE:     tie_d = sat_inc(tie_q);
          default:     ;
        endcase
`ifdef MORRA_TIMEOUT_EN
        state_d = (games_d == num_q || abort_q) ? ST_DONE : ST_CONFIG;
`else
        state_d = (games_d == num_q) ? ST_DONE : ST_CONFIG;
`endif
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      max_q       <= MANCHE_MIN;
      num_q       <= '0;
      games_q     <= '0;
      p1w_q       <= '0;
      p2w_q       <= '0;
      tie_q       <= '0;
      round_res_q <= RES_RUN;
      game_res_q  <= RES_RUN;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      num_q       <= num_d;
      games_q     <= games_d;
      p1w_q       <= p1w_d;
      p2w_q       <= p2w_d;
      tie_q       <= tie_d;
      round_res_q <= round_res_d;
      game_res_q  <= game_res_d;
    end
  end

`ifdef MORRA_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
    end
  end
`endif

  assign game_result = game_res_q;
  assign p1_wins     = p1w_q;
  assign p2_wins     = p2w_q;
  assign ties        = tie_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
